// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 key event decoder.
package kbd_pkg;

    // Prefix-tracking states for scan-code set 2 sequences.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BRK    = 2'd1,
        S_EXT    = 2'd2,
        S_EXTBRK = 2'd3
    } state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_TAB   = 8'h0D;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_SPACE = 8'h29;

endpackage

// File: rtl/kbd_ascii_lut.sv
// Combinational scan-code set 2 to ASCII table for a-z, 0-9 and space.
module kbd_ascii_lut
    import kbd_pkg::*;
(
    input  logic [7:0] code,
    output logic       printable_c,
    output logic [7:0] ascii_c
);

    // Table lookup; a zero result marks a code with no printable mapping.
    always_comb begin
        ascii_c = 8'h00;
        case (code)
            8'h1C:    ascii_c = 8'h61; // a
            8'h32:    ascii_c = 8'h62; // b
            8'h21:    ascii_c = 8'h63; // c
            8'h23:    ascii_c = 8'h64; // d
            8'h24:    ascii_c = 8'h65; // e
            8'h2B:    ascii_c = 8'h66; // f
            8'h34:    ascii_c = 8'h67; // g
            8'h33:    ascii_c = 8'h68; // h
            8'h43:    ascii_c = 8'h69; // i
            8'h3B:    ascii_c = 8'h6A; // j
            8'h42:    ascii_c = 8'h6B; // k
            8'h4B:    ascii_c = 8'h6C; // l
            8'h3A:    ascii_c = 8'h6D; // m
            8'h31:    ascii_c = 8'h6E; // n
            8'h44:    ascii_c = 8'h6F; // o
            8'h4D:    ascii_c = 8'h70; // p
            8'h15:    ascii_c = 8'h71; // q
            8'h2D:    ascii_c = 8'h72; // r
            8'h1B:    ascii_c = 8'h73; // s
            8'h2C:    ascii_c = 8'h74; // t
            8'h3C:    ascii_c = 8'h75; // u
            8'h2A:    ascii_c = 8'h76; // v
            8'h1D:    ascii_c = 8'h77; // w
            8'h22:    ascii_c = 8'h78; // x
            8'h35:    ascii_c = 8'h79; // y
            8'h1A:    ascii_c = 8'h7A; // z
            8'h45:    ascii_c = 8'h30; // 0
            8'h16:    ascii_c = 8'h31; // 1
            8'h1E:    ascii_c = 8'h32; // 2
            8'h26:    ascii_c = 8'h33; // 3
            8'h25:    ascii_c = 8'h34; // 4
            8'h2E:    ascii_c = 8'h35; // 5
            8'h36:    ascii_c = 8'h36; // 6
            8'h3D:    ascii_c = 8'h37; // 7
            8'h3E:    ascii_c = 8'h38; // 8
            8'h46:    ascii_c = 8'h39; // 9
            SC_SPACE: ascii_c = 8'h20; // space
            default:  ascii_c = 8'h00;
        endcase
    end

    assign printable_c = (ascii_c != 8'h00);

endmodule

// File: rtl/key_event_decoder.sv
// PS/2 set 2 byte stream to key events: enter/tab pulses, line-buffer writes, overflow.
module key_event_decoder
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              code_valid,
    input  logic [7:0]        code,
    output logic              enter,
    output logic              tab,
    output logic              overflow,
    output logic              char_we,
    output logic [ADDR_W-1:0] char_addr,
    output logic [7:0]        char_data,
    output logic [ADDR_W:0]   char_count
);

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W+1)'(1);

    state_t              state;
    state_t              state_nxt;
    logic                enter_nxt;
    logic                tab_nxt;
    logic                overflow_nxt;
    logic                char_we_nxt;
    logic [ADDR_W-1:0]   char_addr_nxt;
    logic [7:0]          char_data_nxt;
    logic [ADDR_W:0]     char_count_nxt;
    logic                printable_c;
    logic [7:0]          ascii_c;

    kbd_ascii_lut u_lut (
        .code        (code),
        .printable_c (printable_c),
        .ascii_c     (ascii_c)
    );

    // State and registered outputs; reset drops any pending prefix and empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            enter      <= 1'b0;
            tab        <= 1'b0;
            overflow   <= 1'b0;
            char_we    <= 1'b0;
            char_addr  <= '0;
            char_data  <= '0;
            char_count <= '0;
        end else begin
            state      <= state_nxt;
            enter      <= enter_nxt;
            tab        <= tab_nxt;
            overflow   <= overflow_nxt;
            char_we    <= char_we_nxt;
            char_addr  <= char_addr_nxt;
            char_data  <= char_data_nxt;
            char_count <= char_count_nxt;
        end
    end

    // Next state and next output values; nothing advances without code_valid.
    always_comb begin
        state_nxt      = state;
        enter_nxt      = 1'b0;
        tab_nxt        = 1'b0;
        overflow_nxt   = 1'b0;
        char_we_nxt    = 1'b0;
        char_addr_nxt  = char_addr;
        char_data_nxt  = char_data;
        char_count_nxt = char_count;

        if (code_valid) begin
            case (state)
                S_IDLE: begin
                    if (code == SC_BREAK) begin
                        state_nxt = S_BRK;
                    end else if (code == SC_EXT) begin
                        state_nxt = S_EXT;
                    end else if (code == SC_ENTER) begin
                        enter_nxt      = 1'b1;
                        char_count_nxt = '0;
                    end else if (code == SC_TAB) begin
                        tab_nxt = 1'b1;
                    end else if (code == SC_BKSP) begin
                        if (char_count != '0) begin
                            char_count_nxt = char_count - COUNT_ONE;
                        end
                    end else if (printable_c) begin
                        if (char_count < COUNT_FULL) begin
                            char_we_nxt    = 1'b1;
                            char_addr_nxt  = char_count[ADDR_W-1:0];
                            char_data_nxt  = ascii_c;
                            char_count_nxt = char_count + COUNT_ONE;
                        end else begin
                            overflow_nxt = 1'b1;
                        end
                    end
                end
                S_BRK: begin
                    // A second F0 keeps waiting for the released key's code.
                    if (code != SC_BREAK) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_EXT: begin
                    if (code == SC_BREAK) begin
                        state_nxt = S_EXTBRK;
                    end else begin
                        if (code == SC_ENTER) begin
                            enter_nxt      = 1'b1;
                            char_count_nxt = '0;
                        end
                        state_nxt = S_IDLE;
                    end
                end
                S_EXTBRK: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed vector table plus randomized stream against a sequence-level model.
module tb_key_event_decoder;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 2;

    logic              clk;
    logic              rst;
    logic              code_valid;
    logic [7:0]        code;
    logic              enter;
    logic              tab;
    logic              overflow;
    logic              char_we;
    logic [ADDR_W-1:0] char_addr;
    logic [7:0]        char_data;
    logic [ADDR_W:0]   char_count;

    int checks = 0;
    int errors = 0;

    key_event_decoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .code_valid (code_valid),
        .code       (code),
        .enter      (enter),
        .tab        (tab),
        .overflow   (overflow),
        .char_we    (char_we),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .char_count (char_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] code;
        logic       enter;
        logic       tab;
        logic       ovf;
        logic       we;
        int         addr;
        int         data;
        int         count;
    } vec_t;

    vec_t vecs[$];

    // Keyboard legend: characters and their set 2 make codes, position by position.
    string      chars = "abcdefghijklmnopqrstuvwxyz0123456789 ";
    logic [7:0] sc_tab [37] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
        8'h29
    };

    // Reference model state: bytes of an unfinished sequence and buffer fill.
    logic [7:0] pfx[$];
    int         m_count;

    function automatic vec_t mk(input logic v, input logic [7:0] c, input logic en,
                                input logic tb, input logic ov, input logic we,
                                input int addr, input int data, input int count);
        vec_t r;
        r.valid = v; r.code = c; r.enter = en; r.tab = tb; r.ovf = ov;
        r.we = we; r.addr = addr; r.data = data; r.count = count;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input vec_t e);
        chk({tag, " enter"}, int'(enter), int'(e.enter));
        chk({tag, " tab"}, int'(tab), int'(e.tab));
        chk({tag, " overflow"}, int'(overflow), int'(e.ovf));
        chk({tag, " char_we"}, int'(char_we), int'(e.we));
        chk({tag, " char_count"}, int'(char_count), e.count);
        if (e.we) begin
            chk({tag, " char_addr"}, int'(char_addr), e.addr);
            chk({tag, " char_data"}, int'(char_data), e.data);
        end
    endtask

    // Expected effect of a fully received make code.
    task automatic model_make(input logic [7:0] c, inout vec_t e);
        int idx;
        idx = -1;
        for (int i = 0; i < 37; i++) if (sc_tab[i] == c) idx = i;
        if (c == 8'h5A) begin
            e.enter = 1'b1;
            m_count = 0;
        end else if (c == 8'h0D) begin
            e.tab = 1'b1;
        end else if (c == 8'h66) begin
            if (m_count > 0) m_count--;
        end else if (idx >= 0) begin
            if (m_count < int'(DEPTH)) begin
                e.we   = 1'b1;
                e.addr = m_count;
                e.data = int'(chars[idx]);
                m_count++;
            end else begin
                e.ovf = 1'b1;
            end
        end
    endtask

    // Classify the byte against the pending prefix: grow it, or close the sequence.
    task automatic model_step(input logic v, input logic [7:0] c, output vec_t e);
        e = mk(v, c, 0, 0, 0, 0, 0, 0, 0);
        if (v) begin
            if (c == 8'hF0 && (pfx.size() == 0 || (pfx.size() == 1 && pfx[0] == 8'hE0))) begin
                pfx.push_back(c);
            end else if (c == 8'hF0 && pfx.size() == 1 && pfx[0] == 8'hF0) begin
                // repeated break prefix: still waiting for the key code
            end else if (c == 8'hE0 && pfx.size() == 0) begin
                pfx.push_back(c);
            end else begin
                if (pfx.size() == 0) model_make(c, e);
                else if (pfx.size() == 1 && pfx[0] == 8'hE0 && c == 8'h5A) begin
                    e.enter = 1'b1;
                    m_count = 0;
                end
                pfx.delete();
            end
        end
        e.count = m_count;
    endtask

    // Drive one byte slot after a falling edge and check it one cycle later.
    task automatic apply(input string tag, input vec_t e);
        code_valid = e.valid;
        code       = e.code;
        @(negedge clk);
        chk_outputs(tag, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        code_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pfx.delete();
        m_count = 0;
    endtask

    initial begin
        vec_t e;
        vec_t z;
        rst = 1'b0;
        code_valid = 1'b0;
        code = 8'h00;
        pfx.delete();
        m_count = 0;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk_outputs("reset", z);
        rst = 1'b1;

        vecs.push_back(mk(1, 8'h1C, 0, 0, 0, 1, 0, 8'h61, 1));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h1C, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h45, 0, 0, 0, 1, 1, 8'h30, 2));
        vecs.push_back(mk(1, 8'h16, 0, 0, 0, 1, 2, 8'h31, 3));
        vecs.push_back(mk(1, 8'h1E, 0, 0, 0, 1, 3, 8'h32, 4));
        vecs.push_back(mk(1, 8'h26, 0, 0, 1, 0, 0, 0, 4));
        vecs.push_back(mk(1, 8'h25, 0, 0, 1, 0, 0, 0, 4));
        vecs.push_back(mk(0, 8'h25, 0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(mk(1, 8'h5A, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h5A, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h5A, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h66, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h0D, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h0D, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h29, 0, 0, 0, 1, 0, 8'h20, 1));
        vecs.push_back(mk(1, 8'h66, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h1C, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h1C, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h1C, 0, 0, 0, 1, 0, 8'h61, 1));
        vecs.push_back(mk(1, 8'h1C, 0, 0, 0, 1, 1, 8'h61, 2));
        vecs.push_back(mk(1, 8'h12, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 8'h2B, 0, 0, 0, 1, 2, 8'h66, 3));

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset arriving while a break prefix is pending.
        code_valid = 1'b1;
        code = 8'hF0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_outputs("async_reset", z);
        @(negedge clk);
        code_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        apply("post_reset_write", mk(1, 8'h1C, 0, 0, 0, 1, 0, 8'h61, 1));

        // Randomized byte stream checked against the sequence model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic       v;
            logic [7:0] c;
            int         r;
            v = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 9));
            case (r)
                0:       c = 8'hF0;
                1:       c = 8'hE0;
                2:       c = 8'h5A;
                3:       c = 8'h0D;
                4:       c = 8'h66;
                9:       c = 8'($urandom_range(0, 255));
                default: c = sc_tab[$urandom_range(0, 36)];
            endcase
            model_step(v, c, e);
            apply("rand", e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
